memory_f1_up_writer: RTL and testbench
======================================

// Module: memory_f1_up_writer
// PURPOSE
// Write-side driver for the upper F1 mercury tank. Takes a parallel short word
// (17 bit) or long word (35 bit) plus a tank slot address. Waits for the target
// minor cycle to come round in the circulating tank. Then serialises the word
// onto f1_mib, LSB first, with f1_up_t1_in and f1_up_t1_clr asserted so the new
// data replaces the recirculating content. It is the producer for the tank's
// f1_mib / t1_in / t1_clr inputs.
// PARAMETERS
// WORD_BITS   17  data bits in a short word; a long word is 2*WORD_BITS+1 = 35
// DIGITS      18  digit periods per minor cycle (17 data digits + 1 gap/sandwich)
// SLOTS       32  minor cycles per tank circulation (32 short or 16 long words)
// PORTS
// f1_clk        in   1   digit clock; one cycle = one digit period
// f1_rst        in   1   synchronous, active-high reset
// f1_sync       in   1   pulse marking digit 0 of slot 0 (major-cycle start)
// wr_req        in   1   write request, sampled every cycle
// wr_long       in   1   1 = long word (two slots), 0 = short word
// wr_addr       in   5   short-word slot 0..31; bit 0 ignored when wr_long=1
// wr_data       in   35  word; short uses [16:0]
// wr_ack        out  1   one-cycle pulse: request accepted
// wr_done       out  1   one-cycle pulse: last digit of the word driven
// wr_err        out  1   one-cycle pulse: write aborted by resync
// busy          out  1   high from accept until done/abort
// f1_mib        out  1   serial data to tank input bus
// f1_up_t1_in   out  1   tank input gate
// f1_up_t1_clr  out  1   tank recirculation clear
// BEHAVIOUR
// - Position counters: dig 0..DIGITS-1 and slot 0..SLOTS-1, both wrapping.
//   Effective position in a cycle is (0,0) if f1_sync=1, else the counter value.
//   The counter then advances from the effective position.
// - Reset: dig=0, slot=0, state IDLE. All outputs 0 in the cycle after f1_rst.
// - FSM IDLE -> WAIT -> WRITE -> IDLE.
//   IDLE: if wr_req, latch data, long and addr, then go to WAIT. wr_ack pulses
//     and busy rises in the next cycle. For a long write, addr[0] is forced to 0.
//   WAIT: stays until the effective position is (addr-1 mod SLOTS, DIGITS-1),
//     then goes to WRITE. Outputs are registered, so digit 0 of the target slot
//     carries bit 0. Worst-case accept-to-first-digit is SLOTS*DIGITS cycles.
//   WRITE: the digit count n starts at 0 on the target slot's digit 0.
//     t1_in=t1_clr=1 for every digit of the word.
//     f1_mib = data[n] for n<WORD_BITS (short) or n<35 (long), else 0.
//     Short: 18 digits, last digit (gap) has mib=0.
//     Long: 36 digits across slots addr and addr+1. Digit 17 is the sandwich
//       bit data[17]; digit 35 has mib=0.
//     After the last digit, gates drop to 0 in the next cycle, wr_done pulses
//     in that cycle, and busy falls in that cycle.
// - wr_req while busy: ignored, no ack, no queuing.
// - f1_sync arriving while the counter is not already at (0,0) is a resync.
//   In WAIT, the FSM keeps waiting against the new timing.
//   In WRITE, gates drop next cycle, wr_err pulses, state returns to IDLE,
//   busy falls, and no wr_done is issued.
// - f1_rst mid-write: immediate return to IDLE with all outputs 0. The tank
//   slot may hold a partial word; recovery is the requester's job.
// - Outside WRITE, f1_mib, t1_in and t1_clr are 0.
// TESTING
// 1 reset, sync, short req addr=5 data=17'h1_5A5A -> t1_in/clr high cycles 90..107 after
//   sync, mib = bits LSB-first, gap 0, wr_done at 108.
// 2 long req addr=6 data=35'h5_5555_5555 -> 36 gated digits from cycle 108;
//   digit 17 = data[17]; digit 35 mib=0.
// 3 long req addr=7 -> same timing as addr=6 (bit 0 ignored).
// 4 second wr_req during busy -> no wr_ack, first write completes unchanged.
// 5 f1_sync pulsed at digit 9 of a write -> gates low next cycle, wr_err=1,
//   busy=0, no wr_done.
// 6 f1_rst during WRITE -> all outputs 0 next cycle. A fresh request then
//   completes normally.

Source files
------------

// File: rtl/memory_f1_up_writer.sv
// Write-side driver for the upper F1 mercury tank: waits for the target minor
// cycle, then serialises a short or long word LSB first onto f1_mib with the
// tank input and recirculation-clear gates held high for the whole word.
module memory_f1_up_writer #(
  parameter  int unsigned WORD_BITS = 17,
  parameter  int unsigned DIGITS    = 18,
  parameter  int unsigned SLOTS     = 32,
  localparam int unsigned LONG_BITS = 2 * WORD_BITS + 1,
  localparam int unsigned DIG_W     = $clog2(DIGITS),
  localparam int unsigned SLOT_W    = $clog2(SLOTS),
  localparam int unsigned CNT_W     = $clog2(2 * DIGITS)
) (
  input  logic                 f1_clk,
  input  logic                 f1_rst,
  input  logic                 f1_sync,
  input  logic                 wr_req,
  input  logic                 wr_long,
  input  logic [SLOT_W-1:0]    wr_addr,
  input  logic [LONG_BITS-1:0] wr_data,
  output logic                 wr_ack,
  output logic                 wr_done,
  output logic                 wr_err,
  output logic                 busy,
  output logic                 f1_mib,
  output logic                 f1_up_t1_in,
  output logic                 f1_up_t1_clr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE
  } state_e;

  state_e                state_q, state_d;
  logic [DIG_W-1:0]      dig_q, dig_d, dig_eff;
  logic [SLOT_W-1:0]     slot_q, slot_d, slot_eff;
  logic                  resync;

  logic [LONG_BITS-1:0]  data_q, data_d;
  logic                  long_q, long_d;
  logic [SLOT_W-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0]      n_q, n_d;

  logic                  ack_q, ack_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  mib_q, mib_d;
  logic                  gate_q, gate_d;

  logic [SLOT_W-1:0]     prev_slot;
  logic [CNT_W-1:0]      last_n;
  logic [CNT_W-1:0]      bits_lim;
  logic [CNT_W-1:0]      nxt_n;

  // Effective tank position (sync forces 0,0) and its successor.
  always_comb begin
    dig_eff  = f1_sync ? '0 : dig_q;
    slot_eff = f1_sync ? '0 : slot_q;
    resync   = f1_sync && ((dig_q != '0) || (slot_q != '0));
    dig_d    = dig_eff + DIG_W'(1);
    slot_d   = slot_eff;
    if (dig_eff == DIG_W'(DIGITS - 1)) begin
      dig_d  = '0;
      slot_d = (slot_eff == SLOT_W'(SLOTS - 1)) ? '0 : slot_eff + SLOT_W'(1);
    end
  end

  // Digit/slot position counters.
  always_ff @(posedge f1_clk) begin
    if (f1_rst) begin
      dig_q  <= '0;
      slot_q <= '0;
    end else begin
      dig_q  <= dig_d;
      slot_q <= slot_d;
    end
  end

  // Slot preceding the target, word length and data-bit limit of the latched request.
  always_comb begin
    prev_slot = (addr_q == '0) ? SLOT_W'(SLOTS - 1) : addr_q - SLOT_W'(1);
    last_n    = long_q ? CNT_W'(2 * DIGITS - 1) : CNT_W'(DIGITS - 1);
    bits_lim  = long_q ? CNT_W'(LONG_BITS) : CNT_W'(WORD_BITS);
    nxt_n     = n_q + CNT_W'(1);
  end

  // Next-state and registered-output logic; outputs lead the digit they drive by one cycle.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    long_d  = long_q;
    addr_d  = addr_q;
    n_d     = n_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    mib_d   = 1'b0;
    gate_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (wr_req) begin
          data_d  = wr_data;
          long_d  = wr_long;
          addr_d  = wr_long ? {wr_addr[SLOT_W-1:1], 1'b0} : wr_addr;
          ack_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if ((slot_eff == prev_slot) && (dig_eff == DIG_W'(DIGITS - 1))) begin
          state_d = ST_WRITE;
          n_d     = '0;
          gate_d  = 1'b1;
          mib_d   = data_q[0];
        end
      end
      ST_WRITE: begin
        if (resync) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (n_q == last_n) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          n_d    = nxt_n;
          gate_d = 1'b1;
          mib_d  = (nxt_n < bits_lim) ? data_q[nxt_n] : 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state, latched request and output registers.
  always_ff @(posedge f1_clk) begin
    if (f1_rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      long_q  <= 1'b0;
      addr_q  <= '0;
      n_q     <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      mib_q   <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      long_q  <= long_d;
      addr_q  <= addr_d;
      n_q     <= n_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      mib_q   <= mib_d;
      gate_q  <= gate_d;
    end
  end

  assign wr_ack       = ack_q;
  assign wr_done      = done_q;
  assign wr_err       = err_q;
  assign busy         = busy_q;
  assign f1_mib       = mib_q;
  assign f1_up_t1_in  = gate_q;
  assign f1_up_t1_clr = gate_q;

endmodule

// File: tb/tb_memory_f1_up_writer.sv
// Bench for memory_f1_up_writer: position-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_memory_f1_up_writer;

  localparam int NPOS = 18 * 32;

  logic        clk = 1'b0;
  logic        f1_rst, f1_sync, wr_req, wr_long;
  logic [4:0]  wr_addr;
  logic [34:0] wr_data;
  wire         wr_ack, wr_done, wr_err, busy, f1_mib, t1_in, t1_clr;

  always #5 clk = ~clk;

  memory_f1_up_writer dut (
    .f1_clk      (clk),
    .f1_rst      (f1_rst),
    .f1_sync     (f1_sync),
    .wr_req      (wr_req),
    .wr_long     (wr_long),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .wr_done     (wr_done),
    .wr_err      (wr_err),
    .busy        (busy),
    .f1_mib      (f1_mib),
    .f1_up_t1_in (t1_in),
    .f1_up_t1_clr(t1_clr)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sync_at = 0;
  bit chk_en = 1'b0;

  function automatic void check1(string nm, logic got, logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b at t=%0t", nm, got, exp, $time);
    end
  endfunction

  // Cycle count and the cycle of the most recent sync (for directed positioning).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (f1_sync) sync_at <= cyc + 1;
  end

  // Reference model: linear tank position; a word occupies positions start..start+len-1.
  int          mpos = 0;
  bit          m_act = 1'b0, m_wr = 1'b0;
  int          m_start = 0, m_len = 0, m_bits = 0;
  logic [34:0] m_data = '0;
  logic        e_ack = 0, e_done = 0, e_err = 0, e_busy = 0, e_mib = 0, e_gate = 0;

  always @(posedge clk) begin : ref_model
    int p, np, k, a;
    bit rs;
    if (f1_rst) begin
      mpos = 0; m_act = 0; m_wr = 0;
      e_ack = 0; e_done = 0; e_err = 0; e_busy = 0; e_mib = 0; e_gate = 0;
    end else begin
      p  = f1_sync ? 0 : mpos;
      rs = f1_sync && (mpos != 0);
      np = (p + 1) % NPOS;
      e_ack = 0; e_done = 0; e_err = 0; e_mib = 0; e_gate = 0;
      if (!m_act) begin
        if (wr_req) begin
          a       = wr_long ? (int'(wr_addr) / 2) * 2 : int'(wr_addr);
          m_act   = 1;
          m_wr    = 0;
          m_start = a * 18;
          m_len   = wr_long ? 36 : 18;
          m_bits  = wr_long ? 35 : 17;
          m_data  = wr_data;
          e_ack   = 1;
        end
      end else if (m_wr) begin
        if (rs) begin
          e_err = 1; m_act = 0; m_wr = 0;
        end else begin
          k = (np - m_start + NPOS) % NPOS;
          if (k < m_len) begin
            e_gate = 1;
            e_mib  = (k < m_bits) ? m_data[k] : 1'b0;
          end else begin
            e_done = 1; m_act = 0; m_wr = 0;
          end
        end
      end else if (np == m_start) begin
        m_wr   = 1;
        e_gate = 1;
        e_mib  = m_data[0];
      end
      e_busy = m_act;
      mpos   = np;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check1("model.ack",  wr_ack,  e_ack);
      check1("model.done", wr_done, e_done);
      check1("model.err",  wr_err,  e_err);
      check1("model.busy", busy,    e_busy);
      check1("model.mib",  f1_mib,  e_mib);
      check1("model.in",   t1_in,   e_gate);
      check1("model.clr",  t1_clr,  e_gate);
    end
  end

  // Advance to the interval whose tank position (relative to last sync) is j.
  task automatic goto_pos(int j);
    int guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while ((cyc - sync_at != j - 1) && (guard < 2000));
    if (guard >= 2000) begin
      total++; bad++;
      $display("FAIL goto_pos timeout waiting for position %0d", j);
    end
  endtask

  task automatic check_now(string nm, logic g, logic m, logic d, logic e, logic b);
    @(negedge clk);
    check1({nm, ".in"},   t1_in,   g);
    check1({nm, ".clr"},  t1_clr,  g);
    check1({nm, ".mib"},  f1_mib,  m);
    check1({nm, ".done"}, wr_done, d);
    check1({nm, ".err"},  wr_err,  e);
    check1({nm, ".busy"}, busy,    b);
  endtask

  task automatic expect_at(int j, string nm, logic g, logic m, logic d, logic e, logic b);
    goto_pos(j);
    check_now(nm, g, m, d, e, b);
  endtask

  task automatic do_sync();
    @(posedge clk); #1;
    f1_sync = 1'b1;
    @(posedge clk); #1;
    f1_sync = 1'b0;
  endtask

  // Present a request for one cycle starting now.
  task automatic request(logic lng, logic [4:0] a, logic [34:0] d);
    wr_req = 1'b1; wr_long = lng; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_req = 1'b0; wr_long = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  initial begin
    f1_rst = 1'b1; f1_sync = 1'b0; wr_req = 1'b0; wr_long = 1'b0;
    wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    f1_rst = 1'b0;
    check_now("reset", 0, 0, 0, 0, 0);
    check1("reset.ack", wr_ack, 1'b0);

    // Short word to slot 5: gates at positions 90..107, done at 108.
    do_sync();
    request(1'b0, 5'd5, 35'h1_5A5A);
    @(negedge clk);
    check1("t1.ack", wr_ack, 1'b1);
    check1("t1.busy", busy, 1'b1);
    expect_at(89,  "t1.p89",  0, 0, 0, 0, 1);
    expect_at(90,  "t1.p90",  1, 0, 0, 0, 1);
    expect_at(91,  "t1.p91",  1, 1, 0, 0, 1);
    expect_at(106, "t1.p106", 1, 1, 0, 0, 1);
    expect_at(107, "t1.gap",  1, 0, 0, 0, 1);
    expect_at(108, "t1.done", 0, 0, 1, 0, 0);

    // Long word to slot 6: 36 digits from position 108.
    do_sync();
    request(1'b1, 5'd6, 35'h5_5555_5555);
    expect_at(107, "t2.p107", 0, 0, 0, 0, 1);
    expect_at(108, "t2.p108", 1, 1, 0, 0, 1);
    expect_at(125, "t2.sand", 1, 0, 0, 0, 1);
    expect_at(142, "t2.p142", 1, 1, 0, 0, 1);
    expect_at(143, "t2.gap",  1, 0, 0, 0, 1);
    expect_at(144, "t2.done", 0, 0, 1, 0, 0);

    // Long word to slot 7 behaves as slot 6; a request while busy is ignored.
    do_sync();
    request(1'b1, 5'd7, 35'h4_0002_0001);
    goto_pos(10);
    request(1'b0, 5'd20, 35'h1_FFFF);
    @(negedge clk);
    check1("t4.noack", wr_ack, 1'b0);
    expect_at(107, "t3.p107", 0, 0, 0, 0, 1);
    expect_at(108, "t3.p108", 1, 1, 0, 0, 1);
    expect_at(125, "t3.sand", 1, 1, 0, 0, 1);
    expect_at(126, "t3.p126", 1, 0, 0, 0, 1);
    expect_at(142, "t3.p142", 1, 1, 0, 0, 1);
    expect_at(143, "t3.gap",  1, 0, 0, 0, 1);
    expect_at(144, "t3.done", 0, 0, 1, 0, 0);
    repeat (5) @(negedge clk);
    check1("t4.idle", busy, 1'b0);

    // Resync at digit 9 of a short write to slot 2 aborts it.
    do_sync();
    request(1'b0, 5'd2, 35'h1_FFFF);
    expect_at(45, "t5.d9", 1, 1, 0, 0, 1);
    f1_sync = 1'b1;
    @(posedge clk); #1;
    f1_sync = 1'b0;
    check_now("t5.abort", 0, 0, 0, 1, 0);
    repeat (30) @(negedge clk);

    // Reset mid-write clears everything; a fresh request then completes.
    do_sync();
    request(1'b0, 5'd3, 35'h0_AAAA);
    expect_at(58, "t6.d4", 1, 0, 0, 0, 1);
    f1_rst = 1'b1;
    @(posedge clk); #1;
    f1_rst = 1'b0;
    check_now("t6.rst", 0, 0, 0, 0, 0);
    check1("t6.rst.ack", wr_ack, 1'b0);
    do_sync();
    request(1'b0, 5'd1, 35'h0_0003);
    expect_at(18, "t6.p18", 1, 1, 0, 0, 1);
    expect_at(19, "t6.p19", 1, 1, 0, 0, 1);
    expect_at(20, "t6.p20", 1, 0, 0, 0, 1);
    expect_at(35, "t6.gap", 1, 0, 0, 0, 1);
    expect_at(36, "t6.done", 0, 0, 1, 0, 0);

    // Random traffic with occasional syncs and resets, checked by the model.
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      wr_req  = ($urandom % 6) == 0;
      wr_long = $urandom % 2;
      wr_addr = 5'($urandom);
      wr_data = {3'($urandom), $urandom};
      f1_sync = ($urandom % 400) == 0;
      f1_rst  = ($urandom % 2500) == 0;
    end
    @(posedge clk); #1;
    wr_req = 1'b0; f1_sync = 1'b0; f1_rst = 1'b0;
    repeat (1200) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
